// File: rtl/ls_exec_pkg.sv
// ls_exec_pkg: shared bus widths, idle values, opcode encodings and load/store helpers.
`default_nettype none
package ls_exec_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int NAME_W = 5;
  localparam int OP_W   = 6;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [NAME_W-1:0] name_t;
  typedef logic [OP_W-1:0]   op_t;

  localparam tag_t  TAG_FREE  = '0;
  localparam name_t NAME_FREE = '0;
  localparam data_t DATA_FREE = '0;

  localparam op_t OP_NOP = 6'd0;
  localparam op_t OP_LB  = 6'd1;
  localparam op_t OP_LH  = 6'd2;
  localparam op_t OP_LW  = 6'd3;
  localparam op_t OP_LBU = 6'd4;
  localparam op_t OP_LHU = 6'd5;
  localparam op_t OP_SB  = 6'd6;
  localparam op_t OP_SH  = 6'd7;
  localparam op_t OP_SW  = 6'd8;

  // Zero marks an opcode that completes without touching memory.
  function automatic logic [2:0] op_bytes(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
      OP_LW, OP_SW:         op_bytes = 3'd4;
      default:              op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input op_t op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic data_t op_extend(input op_t op, input data_t raw);
    case (op)
      OP_LB:   op_extend = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   op_extend = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  op_extend = {24'd0, raw[7:0]};
      OP_LHU:  op_extend = {16'd0, raw[15:0]};
      default: op_extend = raw;
    endcase
  endfunction
endpackage
`default_nettype wire

// File: rtl/ls_exec_if.sv
// ls_exec_if: issue, load-result broadcast and byte-serial memory signals of ls_exec.
`default_nettype none
interface ls_exec_if
  import ls_exec_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              LSworkEn;
  data_t             operandO;
  data_t             operandT;
  data_t             imm;
  tag_t              wrtTag;
  name_t             wrtName;
  op_t               opCode;
  logic              LSreadEn;
  logic              LSdone;
  logic              enLSwrt;
  tag_t              LStag;
  data_t             LSdata;
  name_t             LSname;
  logic              memReq;
  logic              memRW;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memWdata;
  logic              memGrant;
  logic [7:0]        memRdata;

  modport slave (
    input  LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode, memGrant, memRdata,
    output LSreadEn, LSdone, enLSwrt, LStag, LSdata, LSname, memReq, memRW, memAddr, memWdata
  );

  modport master (
    output LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode, memGrant, memRdata,
    input  LSreadEn, LSdone, enLSwrt, LStag, LSdata, LSname, memReq, memRW, memAddr, memWdata
  );
endinterface
`default_nettype wire

// File: rtl/ls_exec.sv
// ls_exec: byte-serial load/store execution unit with little-endian assembly and sign/zero extension.
`default_nettype none
module ls_exec
  import ls_exec_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  ls_exec_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  op_t               op;
  tag_t              tag;
  name_t             name;
  data_t             sdata;
  data_t             result;
  logic [1:0]        k;
  logic              cap_pend;
  logic [1:0]        cap_idx;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              done;
  logic              wen;
  tag_t              ls_tag;
  name_t             ls_name;
  data_t             ls_data;

  data_t      addr_sum;
  data_t      result_next;
  logic [1:0] k_next;
  logic       last_byte;

  assign addr_sum  = bus.operandO + bus.imm;
  assign k_next    = k + 2'd1;
  assign last_byte = (({1'b0, k} + 3'd1) == op_bytes(op));

  // The byte granted last cycle is folded in here so WAIT can extend the complete word.
  always_comb begin
    result_next = result;
    if (cap_pend) result_next[{cap_idx, 3'b000} +: 8] = bus.memRdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= OP_NOP;
      tag       <= TAG_FREE;
      name      <= NAME_FREE;
      sdata     <= '0;
      result    <= '0;
      k         <= 2'd0;
      cap_pend  <= 1'b0;
      cap_idx   <= 2'd0;
      mem_req   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      done      <= 1'b0;
      wen       <= 1'b0;
      ls_tag    <= TAG_FREE;
      ls_name   <= NAME_FREE;
      ls_data   <= DATA_FREE;
    end else begin
      if (cap_pend) result <= result_next;
      cap_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.LSworkEn) begin
            op     <= bus.opCode;
            tag    <= bus.wrtTag;
            name   <= bus.wrtName;
            sdata  <= bus.operandT;
            result <= '0;
            k      <= 2'd0;
            if (op_bytes(bus.opCode) != 3'd0) begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_rw    <= op_is_store(bus.opCode);
              mem_addr  <= ADDR_W'(addr_sum);
              mem_wdata <= bus.operandT[7:0];
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (bus.memGrant) begin
            k <= k_next;
            if (!mem_rw) begin
              cap_pend <= 1'b1;
              cap_idx  <= k;
            end
            if (last_byte) begin
              mem_req <= 1'b0;
              mem_rw  <= 1'b0;
              if (mem_rw) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else begin
              mem_addr  <= mem_addr + 1'b1;
              mem_wdata <= sdata[{k_next, 3'b000} +: 8];
            end
          end
        end
        WAIT: begin
          state   <= DONE;
          done    <= 1'b1;
          wen     <= 1'b1;
          ls_tag  <= tag;
          ls_name <= name;
          ls_data <= op_extend(op, result_next);
        end
        default: begin
          state   <= IDLE;
          k       <= 2'd0;
          done    <= 1'b0;
          wen     <= 1'b0;
          ls_tag  <= TAG_FREE;
          ls_name <= NAME_FREE;
          ls_data <= DATA_FREE;
        end
      endcase
    end
  end

  assign bus.LSreadEn = (state == IDLE) && !bus.LSworkEn;
  assign bus.LSdone   = done;
  assign bus.enLSwrt  = wen;
  assign bus.LStag    = ls_tag;
  assign bus.LSname   = ls_name;
  assign bus.LSdata   = ls_data;
  assign bus.memReq   = mem_req;
  assign bus.memRW    = mem_rw;
  assign bus.memAddr  = mem_addr;
  assign bus.memWdata = mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_ls_exec.sv
// tb_ls_exec: scoreboard bench for ls_exec with a byte memory model, grant stalls and a reference load/store model.
`default_nettype none
module tb_ls_exec;
  import ls_exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ls_exec_if #(.ADDR_W(32)) bus ();
  ls_exec #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [7:0]  wdata;
  } acc_t;

  typedef struct {
    int    kind;   // 0 = no memory op, 1 = load, 2 = store
    tag_t  tag;
    name_t name;
    data_t data;
    int    issue_cyc;
    int    base_lat;
  } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];

  logic [7:0] mem [int unsigned];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;
  int last_issue_cyc = 0;
  int last_done_cyc = 0;
  data_t last_data = '0;

  logic [31:0] stall_addr = '0;
  int stall_left = 0;
  bit rand_stall = 1'b0;
  bit rd_pend = 1'b0;
  logic [31:0] rd_addr = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic int nbytes(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  // Memory responder: grants after outputs settle, returns read data one cycle later.
  always @(posedge clk) begin
    bit g;
    #1;
    bus.memRdata = rd_pend ? rd(rd_addr) : 8'h00;
    rd_pend = 1'b0;
    g = 1'b1;
    if (rst) g = 1'b0;
    else if (bus.memReq) begin
      if (stall_left > 0 && bus.memAddr == stall_addr) begin
        g = 1'b0;
        stall_left--;
      end else if (rand_stall && $urandom_range(3) == 0) g = 1'b0;
    end
    bus.memGrant = g;
    if (g && bus.memReq) begin
      if (bus.memRW) mem[bus.memAddr] = bus.memWdata;
      else begin
        rd_pend = 1'b1;
        rd_addr = bus.memAddr;
      end
    end
  end

  // Monitor: checks every request against the expected access stream and every completion.
  always @(negedge clk) begin
    if (rst) stalls = 0;
    else begin
      if (bus.memReq) begin
        if (acc_q.size() == 0) fail("unexpected_mem_req");
        else begin
          chk("mem_addr", bus.memAddr, acc_q[0].addr);
          chk("mem_rw", 32'(bus.memRW), 32'(acc_q[0].rw));
          if (acc_q[0].rw) chk("mem_wdata", 32'(bus.memWdata), 32'(acc_q[0].wdata));
          if (bus.memGrant) void'(acc_q.pop_front());
        end
        if (!bus.memGrant) stalls++;
      end
      if (bus.LSdone) begin
        chk("readen_busy", 32'(bus.LSreadEn), 32'd0);
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          done_t e;
          e = done_q[0];
          chk("done_cycle", 32'(cyc), 32'(e.issue_cyc + e.base_lat + stalls));
          chk("en_wrt", 32'(bus.enLSwrt), 32'(e.kind == 1));
          if (e.kind == 1) begin
            chk("ls_tag", 32'(bus.LStag), 32'(e.tag));
            chk("ls_name", 32'(bus.LSname), 32'(e.name));
            chk("ls_data", bus.LSdata, e.data);
          end
          last_data = bus.LSdata;
          last_done_cyc = cyc;
          stalls = 0;
          void'(done_q.pop_front());
        end
      end else begin
        chk("idle_en_wrt", 32'(bus.enLSwrt), 32'd0);
        chk("idle_data", bus.LSdata, DATA_FREE);
        chk("idle_tag_name", 32'({bus.LStag, bus.LSname}), 32'({TAG_FREE, NAME_FREE}));
      end
    end
  end

  // Called at a negative edge; pushes the reference result then drives one issue cycle.
  task automatic issue(input op_t op, input data_t o, input data_t t, input data_t im);
    int w = 0;
    int n;
    logic [31:0] a;
    done_t e;
    while (!bus.LSreadEn && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.LSreadEn) begin
      fail("issue_ready_timeout");
      return;
    end
    n = nbytes(op);
    a = o + im;
    e.tag = tag_t'($urandom);
    e.name = name_t'($urandom);
    e.issue_cyc = cyc;
    e.data = '0;
    if (n == 0) begin
      e.kind = 0;
      e.base_lat = 1;
    end else if (op == OP_SB || op == OP_SH || op == OP_SW) begin
      e.kind = 2;
      e.base_lat = n + 1;
      for (int i = 0; i < n; i++) acc_q.push_back('{a + 32'(i), 1'b1, 8'((t >> (8 * i)) & 32'hFF)});
    end else begin
      longint v = 0;
      e.kind = 1;
      e.base_lat = n + 2;
      for (int i = 0; i < n; i++) begin
        v += longint'(rd(a + 32'(i))) << (8 * i);
        acc_q.push_back('{a + 32'(i), 1'b0, 8'h00});
      end
      if (op == OP_LB && v >= 128) v -= 256;
      if (op == OP_LH && v >= 32768) v -= 65536;
      e.data = data_t'(v);
    end
    done_q.push_back(e);
    last_issue_cyc = cyc;
    bus.opCode = op;
    bus.operandO = o;
    bus.operandT = t;
    bus.imm = im;
    bus.wrtTag = e.tag;
    bus.wrtName = e.name;
    bus.LSworkEn = 1'b1;
    @(negedge clk);
    bus.LSworkEn = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((done_q.size() != 0 || acc_q.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (done_q.size() != 0 || acc_q.size() != 0) begin
      fail("drain_timeout");
      done_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    op_t ops[10];
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_NOP, 6'h3F};
    bus.LSworkEn = 1'b0;
    bus.operandO = '0;
    bus.operandT = '0;
    bus.imm = '0;
    bus.wrtTag = '0;
    bus.wrtName = '0;
    bus.opCode = OP_NOP;
    bus.memGrant = 1'b0;
    bus.memRdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_readen", 32'(bus.LSreadEn), 32'd1);
    chk("rst_memreq", 32'(bus.memReq), 32'd0);
    chk("rst_memaddr", bus.memAddr, 32'd0);
    chk("rst_memwdata_rw", 32'({bus.memWdata, bus.memRW}), 32'd0);
    chk("rst_done", 32'(bus.LSdone), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    mem[32'h104] = 8'h78; mem[32'h105] = 8'h56; mem[32'h106] = 8'h34; mem[32'h107] = 8'h12;
    issue(OP_LW, 32'h100, 32'h0, 32'd4);
    drain();
    chk("lw_data", last_data, 32'h12345678);
    chk("lw_latency", 32'(last_done_cyc - last_issue_cyc), 32'd6);

    mem[32'h400] = 8'h80;
    issue(OP_LB, 32'h400, 32'h0, 32'h0);
    drain();
    chk("lb_data", last_data, 32'hFFFFFF80);
    chk("lb_latency", 32'(last_done_cyc - last_issue_cyc), 32'd3);
    issue(OP_LBU, 32'h401, 32'h0, 32'hFFFFFFFF);
    drain();
    chk("lbu_data", last_data, 32'h00000080);
    chk("lbu_latency", 32'(last_done_cyc - last_issue_cyc), 32'd3);

    issue(OP_SH, 32'h200, 32'hABCD1234, 32'd3);
    drain();
    chk("sh_byte0", 32'(rd(32'h203)), 32'h34);
    chk("sh_byte1", 32'(rd(32'h204)), 32'h12);
    chk("sh_latency", 32'(last_done_cyc - last_issue_cyc), 32'd3);

    stall_addr = 32'h602;
    stall_left = 3;
    issue(OP_LW, 32'h600, 32'h0, 32'h0);
    drain();
    chk("stall_latency", 32'(last_done_cyc - last_issue_cyc), 32'd9);

    issue(OP_LH, 32'hFFFFFFFF, 32'h0, 32'h0);
    drain();

    issue(OP_NOP, 32'h0, 32'h0, 32'h0);
    drain();
    chk("nop_latency", 32'(last_done_cyc - last_issue_cyc), 32'd1);

    // Protocol violation while busy: the extra strobe must be ignored.
    issue(OP_LW, 32'h700, 32'h0, 32'h0);
    chk("busy_readen", 32'(bus.LSreadEn), 32'd0);
    bus.opCode = OP_NOP;
    bus.LSworkEn = 1'b1;
    @(negedge clk);
    bus.LSworkEn = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    stall_addr = 32'h501;
    stall_left = 5;
    issue(OP_SW, 32'h500, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_memreq", 32'(bus.memReq), 32'd0);
    chk("rst_mid_done", 32'(bus.LSdone), 32'd0);
    done_q.delete();
    acc_q.delete();
    stall_left = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_readen", 32'(bus.LSreadEn), 32'd1);
    chk("rst_mid_memaddr", bus.memAddr, 32'd0);
    @(negedge clk);
    mem[32'h800] = 8'h11; mem[32'h801] = 8'h22; mem[32'h802] = 8'h33; mem[32'h803] = 8'h44;
    issue(OP_LW, 32'h800, 32'h0, 32'h0);
    drain();
    chk("post_rst_lw", last_data, 32'h44332211);

    for (int i = 0; i < 60; i++) begin
      rand_stall = 1'($urandom_range(1));
      issue(ops[$urandom_range(9)], 32'h300 + 32'($urandom_range(63)), data_t'($urandom),
            data_t'(int'($urandom_range(16)) - 8));
      if ($urandom_range(3) == 0) drain();
    end
    drain();
    rand_stall = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
